difftest_commit_fifo: RTL
=========================

// Module: difftest_commit_fifo
// PURPOSE
//  Elastic sink for the per-cycle difftest commit bundle (up to CW records/cycle, valid mask).
//  Compacts valid lanes in lane order into a circular buffer and drains one record/cycle
//  over a valid/ready port to the trace consumer (DPI bridge / trace RAM writer).
//  The commit side cannot stall. Overflow drops the whole cycle's group and is flagged.
// PARAMETERS
//  CONFIG_P_COMMIT_WIDTH  1   log2 commit lanes; CW = 1<<P
//  CONFIG_DW              32  register write-data width
//  CONFIG_PC_W            30  PC width (word address)
//  CONFIG_INSN_DW         32  instruction width
//  CONFIG_LRF_AW          5   logical register address width
//  CONFIG_P_FIFO_DEPTH    3   log2 FIFO entries; DEPTH = 1<<P, must be >= CW
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous active-high reset
//  i_valid    in   CW         per-lane commit valid
//  i_pc       in   PC_W*CW    per-lane PC
//  i_insn     in   INSN_DW*CW per-lane instruction
//  i_wen      in   CW         per-lane RF write enable
//  i_wnum     in   LRF_AW*CW  per-lane RF write address
//  i_wdata    in   DW*CW      per-lane RF write data
//  i_excp     in   1          exception on lane 0
//  i_excp_vect in  8          exception vector, lane 0
//  o_valid    out  1          head record available
//  o_ready    in   1          consumer accepts head
//  o_pc/o_insn/o_wen/o_wnum/o_wdata/o_excp/o_excp_vect  out  single-lane widths  head record
//  o_seq      out  32         sequence number of head record
//  o_overflow out  1          sticky: a group was dropped
//  o_drop_cnt out  16         count of dropped records, saturating
// BEHAVIOUR
//  - Reset: wptr=rptr=0, count=0, o_valid=0, o_seq=0, o_overflow=0, o_drop_cnt=0.
//    Head data outputs read 0 while empty.
//  - Push: n = popcount(i_valid). Lane k with i_valid[k] goes to slot wptr + (number of
//    valid lanes below k), mod DEPTH. wptr += n. Holes in the mask are compacted.
//  - An i_excp record rides with lane 0. If i_excp=1 and i_valid[0]=0, a lane-0 record is
//    still pushed with o_wen=0 (the exception-only commit).
//  - Space check uses count at the start of the cycle. A same-cycle pop does NOT free space
//    for the same-cycle push.
//  - If n > DEPTH-count, drop the whole group (no partial push), set o_overflow,
//    and add n to o_drop_cnt (saturates at 16'hFFFF).
//  - Pop: first-word-fall-through. o_valid = (count!=0); head = mem[rptr], combinational.
//    On o_valid&o_ready: rptr++ and o_seq++ (wraps at 2^32).
//    o_ready while empty is ignored.
//  - Simultaneous push and pop: count_next = count + n_accepted - pop.
//    Must be correct at count = DEPTH-1 and count = DEPTH.
//  - Pointers are P_FIFO_DEPTH+1 bits; full/empty is decided by the MSB compare.
//    Wrap-around is mid-group safe.
//  - Latency: a record pushed in cycle t is visible at o_valid in cycle t+1.
//  - Reset asserted mid-drain discards all contents. o_overflow clears only on reset.
//  - All stored fields are held until popped. The head must be stable while o_valid&!o_ready.
// CONFIGURATION
//  NCPU_DIFFTEST_TSTAMP_EN
//    Defined: adds a free-running 32-bit cycle counter (reset 0, counts every cycle).
//      The counter value in the push cycle is stored per record.
//      Extra output o_tstamp[31:0] gives the head's push-cycle stamp (0 when empty).
//    Undefined: no counter, no o_tstamp port, no timestamp storage.
// TESTING
//  1. CW=2. Push i_valid=2'b11, pc={0x10,0x11}, o_ready=1 -> o_valid for 2 cycles;
//     pc 0x10 with o_seq=0, then 0x11 with o_seq=1.
//  2. i_valid=2'b10, lane1 pc=0x20 -> stored in one slot, count=1; head pc=0x20, lane-0 fields unused.
//  3. DEPTH=8, o_ready=0, push 2 per cycle for 4 cycles -> count=8.
//     5th push drops both: o_overflow=1, o_drop_cnt=2, count stays 8.
//  4. count=7, o_ready=1, push 2 -> dropped (start-of-cycle check); count=6, drop_cnt+=2.
//  5. i_excp=1, i_excp_vect=0x0C, i_valid=0 -> one record: o_excp=1, o_excp_vect=0x0C, o_wen=0.
//  6. Fill to 5, assert rst for 1 cycle -> o_valid=0, o_seq=0, o_overflow=0 next cycle.
//     With TSTAMP_EN: first push at cycle 3 after reset gives o_tstamp=3.

Source files
------------

// File: rtl/difftest_commit_fifo_if.sv
// Commit-bundle sink / trace-drain bus for difftest_commit_fifo.
// NCPU_DIFFTEST_TSTAMP_EN adds the o_tstamp head field.
interface difftest_commit_fifo_if #(
    parameter int CONFIG_P_COMMIT_WIDTH = 1,
    parameter int CONFIG_DW             = 32,
    parameter int CONFIG_PC_W           = 30,
    parameter int CONFIG_INSN_DW        = 32,
    parameter int CONFIG_LRF_AW         = 5
);
    localparam int CW = 1 << CONFIG_P_COMMIT_WIDTH;

    // Commit side (cannot stall)
    logic [CW-1:0]                  i_valid;
    logic [CONFIG_PC_W*CW-1:0]      i_pc;
    logic [CONFIG_INSN_DW*CW-1:0]   i_insn;
    logic [CW-1:0]                  i_wen;
    logic [CONFIG_LRF_AW*CW-1:0]    i_wnum;
    logic [CONFIG_DW*CW-1:0]        i_wdata;
    logic                           i_excp;
    logic [7:0]                     i_excp_vect;

    // Drain side
    logic                           o_valid;
    logic                           o_ready;
    logic [CONFIG_PC_W-1:0]         o_pc;
    logic [CONFIG_INSN_DW-1:0]      o_insn;
    logic                           o_wen;
    logic [CONFIG_LRF_AW-1:0]       o_wnum;
    logic [CONFIG_DW-1:0]           o_wdata;
    logic                           o_excp;
    logic [7:0]                     o_excp_vect;
    logic [31:0]                    o_seq;
    logic                           o_overflow;
    logic [15:0]                    o_drop_cnt;
`ifdef NCPU_DIFFTEST_TSTAMP_EN
    logic [31:0]                    o_tstamp;
`endif

    modport master (
        output i_valid, i_pc, i_insn, i_wen, i_wnum, i_wdata, i_excp, i_excp_vect, o_ready,
        input  o_valid, o_pc, o_insn, o_wen, o_wnum, o_wdata, o_excp, o_excp_vect,
               o_seq, o_overflow, o_drop_cnt
`ifdef NCPU_DIFFTEST_TSTAMP_EN
        , input o_tstamp
`endif
    );

    modport slave (
        input  i_valid, i_pc, i_insn, i_wen, i_wnum, i_wdata, i_excp, i_excp_vect, o_ready,
        output o_valid, o_pc, o_insn, o_wen, o_wnum, o_wdata, o_excp, o_excp_vect,
               o_seq, o_overflow, o_drop_cnt
`ifdef NCPU_DIFFTEST_TSTAMP_EN
        , output o_tstamp
`endif
    );
endinterface

// File: rtl/difftest_commit_fifo.sv
// Elastic sink for the difftest commit bundle: compacts valid lanes into a circular
// buffer, drains one record per cycle (FWFT). NCPU_DIFFTEST_TSTAMP_EN adds push stamps.
module difftest_commit_fifo #(
    parameter int CONFIG_P_COMMIT_WIDTH = 1,
    parameter int CONFIG_DW             = 32,
    parameter int CONFIG_PC_W           = 30,
    parameter int CONFIG_INSN_DW        = 32,
    parameter int CONFIG_LRF_AW         = 5,
    parameter int CONFIG_P_FIFO_DEPTH   = 3
) (
    input logic                 clk,
    input logic                 rst,
    difftest_commit_fifo_if.slave io
);
    localparam int unsigned CW    = 1 << CONFIG_P_COMMIT_WIDTH;
    localparam int unsigned DEPTH = 1 << CONFIG_P_FIFO_DEPTH;
    localparam int unsigned PW    = CONFIG_P_FIFO_DEPTH;

    typedef logic [PW:0] ptr_t;

    logic [CONFIG_PC_W-1:0]    mem_pc    [DEPTH];
    logic [CONFIG_INSN_DW-1:0] mem_insn  [DEPTH];
    logic                      mem_wen   [DEPTH];
    logic [CONFIG_LRF_AW-1:0]  mem_wnum  [DEPTH];
    logic [CONFIG_DW-1:0]      mem_wdata [DEPTH];
    logic                      mem_excp  [DEPTH];
    logic [7:0]                mem_vect  [DEPTH];
`ifdef NCPU_DIFFTEST_TSTAMP_EN
    logic [31:0]               mem_ts    [DEPTH];
    logic [31:0]               cycle_cnt;
`endif

    ptr_t          wptr, rptr, count, free, n;
    logic [PW-1:0] slot [CW];
    logic [CW-1:0] lane_v;
    logic          accept, empty, pop;
    logic [PW-1:0] head_idx;
    logic [31:0]   seq;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic [16:0]   drop_sum;

    // An exception with no lane-0 commit still occupies lane 0 as a record.
    always_comb begin
        lane_v    = io.i_valid;
        lane_v[0] = io.i_valid[0] | io.i_excp;
        n         = '0;
        for (int unsigned k = 0; k < CW; k++) begin
            slot[k] = wptr[PW-1:0] + n[PW-1:0];
            n       = n + ptr_t'(lane_v[k]);
        end
    end

    // Space is judged on start-of-cycle occupancy; a same-cycle pop does not help.
    assign empty    = (wptr == rptr);
    assign count    = wptr - rptr;
    assign free     = ptr_t'(DEPTH) - count;
    assign accept   = (n <= free);
    assign pop      = !empty && io.o_ready;
    assign head_idx = rptr[PW-1:0];
    assign drop_sum = {1'b0, drop_cnt} + 17'(n);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            seq      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                wptr <= wptr + n;
            end else begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
            end
            if (pop) begin
                rptr <= rptr + ptr_t'(1);
                seq  <= seq + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < CW; k++) begin
            if (accept && lane_v[k]) begin
                mem_pc[slot[k]]    <= io.i_pc[k*CONFIG_PC_W +: CONFIG_PC_W];
                mem_insn[slot[k]]  <= io.i_insn[k*CONFIG_INSN_DW +: CONFIG_INSN_DW];
                mem_wen[slot[k]]   <= io.i_wen[k] & io.i_valid[k];
                mem_wnum[slot[k]]  <= io.i_wnum[k*CONFIG_LRF_AW +: CONFIG_LRF_AW];
                mem_wdata[slot[k]] <= io.i_wdata[k*CONFIG_DW +: CONFIG_DW];
                mem_excp[slot[k]]  <= (k == 0) ? io.i_excp : 1'b0;
                mem_vect[slot[k]]  <= (k == 0) ? io.i_excp_vect : 8'h00;
`ifdef NCPU_DIFFTEST_TSTAMP_EN
                mem_ts[slot[k]]    <= cycle_cnt;
`endif
            end
        end
    end

`ifdef NCPU_DIFFTEST_TSTAMP_EN
    always_ff @(posedge clk) begin
        if (rst) cycle_cnt <= '0;
        else     cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign io.o_tstamp = empty ? '0 : mem_ts[head_idx];
`endif

    assign io.o_valid     = !empty;
    assign io.o_pc        = empty ? '0 : mem_pc[head_idx];
    assign io.o_insn      = empty ? '0 : mem_insn[head_idx];
    assign io.o_wen       = empty ? 1'b0 : mem_wen[head_idx];
    assign io.o_wnum      = empty ? '0 : mem_wnum[head_idx];
    assign io.o_wdata     = empty ? '0 : mem_wdata[head_idx];
    assign io.o_excp      = empty ? 1'b0 : mem_excp[head_idx];
    assign io.o_excp_vect = empty ? '0 : mem_vect[head_idx];
    assign io.o_seq       = seq;
    assign io.o_overflow  = overflow;
    assign io.o_drop_cnt  = drop_cnt;
endmodule
